// File: rtl/dec_syndrome_gen.sv
// dec_syndrome_gen
//   Bit-serial syndrome generator for the shortened BCH(63,51) DEC code
//   (t=2, GF(2^6), primitive polynomial x^6+x+1). A received codeword is
//   accepted in IDLE. Its S1 = r(a) and S3 = r(a^3) are then evaluated by
//   Horner's rule, one coefficient per cycle, starting at the highest
//   coefficient. In DONE the word is classified as no / single / double error.
//
// Ports
//   clk        : single clock, all state on posedge
//   rst_n      : synchronous reset, active low
//   in_valid   : in_code carries a codeword
//   in_ready   : block is idle and can accept a codeword
//   in_code    : received word, bit i = coefficient of x^i
//   out_valid  : s1/s3/flags are valid and held until out_ready
//   out_ready  : downstream takes the result
//   s1, s3     : syndromes
//   no_err     : S1==0 and S3==0
//   single_err : S1!=0 and S1^3==S3
//   double_err : anything else (double or uncorrectable)
module dec_syndrome_gen #(
    parameter int N_BITS = 44,
    parameter int M      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M-1:0]      s1,
    output logic [M-1:0]      s3,
    output logic              no_err,
    output logic              single_err,
    output logic              double_err
);

    localparam int CW = $clog2(N_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Multiply by alpha: shift left, and reduce x^6 = x + 1 when bit 5 falls out.
    function automatic logic [M-1:0] mul_a(input logic [M-1:0] x);
        logic [M-1:0] y;
        y = {x[M-2:0], 1'b0};
        if (x[M-1]) y = y ^ M'(3);
        return y;
    endfunction

    // General GF(2^6) product, Horner over the bits of b (MSB first).
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        p = '0;
        for (int i = M - 1; i >= 0; i--) begin
            p = mul_a(p);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    state_t            state_q, state_d;
    logic [N_BITS-1:0] code_q, code_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [M-1:0]      acc1_q, acc1_d;
    logic [M-1:0]      acc3_q, acc3_d;
    logic [M-1:0]      s1_q, s1_d;
    logic [M-1:0]      s3_q, s3_d;
    logic              out_valid_q, out_valid_d;
    logic              no_err_q, no_err_d;
    logic              single_err_q, single_err_d;
    logic              double_err_q, double_err_d;

    logic              r_bit;
    logic [M-1:0]      acc1_nxt, acc3_nxt;
    logic [M-1:0]      s1_cube;
    logic              f_no, f_single;

    // The code register is shifted left each SHIFT cycle, so the current
    // coefficient is always the top bit (highest power first).
    assign r_bit    = code_q[N_BITS-1];
    assign acc1_nxt = mul_a(acc1_q) ^ {{(M-1){1'b0}}, r_bit};
    assign acc3_nxt = mul_a(mul_a(mul_a(acc3_q))) ^ {{(M-1){1'b0}}, r_bit};

    // Classification from the finished accumulators, consumed on DONE entry.
    assign s1_cube  = gf_mul(gf_mul(acc1_q, acc1_q), acc1_q);
    assign f_no     = (acc1_q == '0) && (acc3_q == '0);
    assign f_single = (acc1_q != '0) && (s1_cube == acc3_q);

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        cnt_d        = cnt_q;
        acc1_d       = acc1_q;
        acc3_d       = acc3_q;
        s1_d         = s1_q;
        s3_d         = s3_q;
        out_valid_d  = out_valid_q;
        no_err_d     = no_err_q;
        single_err_d = single_err_q;
        double_err_d = double_err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    code_d  = in_code;
                    acc1_d  = '0;
                    acc3_d  = '0;
                    cnt_d   = CW'(N_BITS - 1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc1_d = acc1_nxt;
                acc3_d = acc3_nxt;
                code_d = {code_q[N_BITS-2:0], 1'b0};
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    // First DONE cycle: publish the result.
                    s1_d         = acc1_q;
                    s3_d         = acc3_q;
                    no_err_d     = f_no;
                    single_err_d = !f_no && f_single;
                    double_err_d = !f_no && !f_single;
                    out_valid_d  = 1'b1;
                end else if (out_ready) begin
                    // Flags drop with out_valid; syndromes simply hold.
                    out_valid_d  = 1'b0;
                    no_err_d     = 1'b0;
                    single_err_d = 1'b0;
                    double_err_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            cnt_q        <= '0;
            acc1_q       <= '0;
            acc3_q       <= '0;
            s1_q         <= '0;
            s3_q         <= '0;
            out_valid_q  <= 1'b0;
            no_err_q     <= 1'b0;
            single_err_q <= 1'b0;
            double_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
            acc1_q       <= acc1_d;
            acc3_q       <= acc3_d;
            s1_q         <= s1_d;
            s3_q         <= s3_d;
            out_valid_q  <= out_valid_d;
            no_err_q     <= no_err_d;
            single_err_q <= single_err_d;
            double_err_q <= double_err_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = out_valid_q;
    assign s1         = s1_q;
    assign s3         = s3_q;
    assign no_err     = no_err_q;
    assign single_err = single_err_q;
    assign double_err = double_err_q;

endmodule

// File: tb/tb_dec_syndrome_gen.sv
// Scoreboarded bench for dec_syndrome_gen: the driver pushes the expected
// syndromes/flags when a word is accepted; the monitor pops and compares
// when the DUT raises out_valid and checks that held outputs stay stable.
module tb_dec_syndrome_gen;
    localparam int N = 44;
    localparam int M = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_code = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [M-1:0] s1, s3;
    logic         no_err, single_err, double_err;

    dec_syndrome_gen #(.N_BITS(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .s1(s1), .s3(s3), .no_err(no_err), .single_err(single_err),
        .double_err(double_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [M-1:0] s1;
        logic [M-1:0] s3;
        logic         no;
        logic         si;
        logic         db;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_tab[0:62];
    int   log_tab[0:63];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Field tables: alpha^i as integers, alpha^6 = alpha + 1.
    task automatic build_tables();
        int v;
        exp_tab[0] = 1;
        for (int i = 1; i < 63; i++) begin
            v = exp_tab[i-1] * 2;
            if (v >= 64) v = (v - 64) ^ 3;
            exp_tab[i] = v;
        end
        for (int i = 0; i < 64; i++) log_tab[i] = 0;
        for (int i = 0; i < 63; i++) log_tab[exp_tab[i]] = i;
    endtask

    // Syndromes as sums of alpha powers; the cube via logarithms.
    function automatic exp_t model(input logic [N-1:0] c);
        exp_t e;
        int   a, b, cube;
        a = 0;
        b = 0;
        for (int i = 0; i < N; i++)
            if (c[i]) begin
                a = a ^ exp_tab[i % 63];
                b = b ^ exp_tab[(3 * i) % 63];
            end
        cube = (a == 0) ? 0 : exp_tab[(3 * log_tab[a]) % 63];
        e.s1 = M'(a);
        e.s3 = M'(b);
        e.no = (a == 0) && (b == 0);
        e.si = (a != 0) && (cube == b);
        e.db = !(e.no || e.si);
        return e;
    endfunction

    // Monitor
    logic seen = 1'b0;
    exp_t cap;
    always @(negedge clk) begin
        exp_t e;
        exp_t cur;
        cur = '{s1: s1, s3: s3, no: no_err, si: single_err, db: double_err};
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(cur), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("s1", 64'(s1), 64'(e.s1));
                    chk("s3", 64'(s3), 64'(e.s3));
                    chk("flags", 64'({no_err, single_err, double_err}), 64'({e.no, e.si, e.db}));
                end
                chk("onehot", 64'($countones({no_err, single_err, double_err})), 64'(1));
                cap  = cur;
                seen = 1'b1;
            end else begin
                chk("hold_stable", 64'(cur), 64'(cap));
            end
            if (out_ready) seen = 1'b0;
        end else begin
            chk("flags_idle", 64'({no_err, single_err, double_err}), 64'(0));
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic send(input logic [N-1:0] code, input int hold);
        int c;
        wait_ready();
        in_valid = 1'b1;
        in_code  = code;
        @(posedge clk);
        q.push_back(model(code));
        #1;
        in_valid = 1'b0;
        in_code  = N'({$urandom, $urandom});   // must be ignored after accept
        c = 0;
        while (!out_valid && c < 200) begin
            in_valid = (c == 5);                // request while busy: ignored
            @(posedge clk); #1;
            c++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(c), 64'(N + 1));
        for (int h = 0; h < hold; h++) begin
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_out_valid", 64'(out_valid), 64'(0));
        chk("drain_in_ready", 64'(in_ready), 64'(1));
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [63:0] w;
        int          k;
        k = $urandom_range(0, 3);
        case (k)
            0: w = {$urandom, $urandom};
            1: w = 64'(1) << $urandom_range(0, N - 1);
            2: w = (64'(1) << $urandom_range(0, N - 1)) | (64'(1) << $urandom_range(0, N - 1));
            default: w = ($urandom_range(0, 1) == 1) ? (64'(1) << (N - 1)) : 64'(0);
        endcase
        return N'(w);
    endfunction

    initial begin
        build_tables();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_outputs", 64'({s1, s3, no_err, single_err, double_err}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        send(N'(0), 0);
        send(N'(1), 0);
        send(N'(2), 0);
        send(N'(64), 0);
        send(N'(3), 0);
        send(N'(1) << (N - 1), 0);
        send(N'({$urandom, $urandom}), 10);

        // Abort a word mid-SHIFT with reset; nothing of it may survive.
        wait_ready();
        in_valid = 1'b1;
        in_code  = N'({$urandom, $urandom}) | N'(1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_outputs", 64'({s1, s3, no_err, single_err, double_err}), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        send(N'(2), 0);

        for (int n = 0; n < 40; n++) send(rand_word(), $urandom_range(0, 3));

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
